// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter feeding a shared 32-bit barrel right shifter (SHIFT_ARB_ROTATE_EN enables rotate mode).
// Latency: grant in cycle N, registered rsp strobe and res_y in cycle N+1; one shift per cycle.
// Backpressure: stall suppresses all grants; responses have no backpressure and must be taken in the strobe cycle.
module shift_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        req_a,
    input  logic [31:0] x_a,
    input  logic [4:0]  sc_a,
    input  logic        md_a,
    input  logic        req_b,
    input  logic [31:0] x_b,
    input  logic [4:0]  sc_b,
    input  logic        md_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        rsp_a,
    output logic        rsp_b,
    output logic [31:0] res_y
);

    // pri: 0 favours port A, 1 favours port B
    logic        pri;
    logic        any_gnt;
    logic [31:0] sel_x;
    logic [4:0]  sel_sc;
    logic [31:0] shift_y;

    // Arithmetic shift right: vacated upper bits take the sign bit
    function automatic logic [31:0] asr32(input logic [31:0] x, input logic [4:0] sc);
        return $unsigned($signed(x) >>> sc);
    endfunction

`ifdef SHIFT_ARB_ROTATE_EN
    logic sel_md;

    // Rotate right: shifting a doubled word keeps sc=0 well defined
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] sc);
        logic [63:0] dbl;
        dbl = {x, x} >> sc;
        return dbl[31:0];
    endfunction
`else
    // Mode inputs have no effect when the rotate path is not built
    logic unused_md;
    assign unused_md = md_a ^ md_b;
`endif

    // Grant selection: stall or reset blocks everything, otherwise the favoured port wins contention
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst && !stall) begin
            if (req_a && req_b) begin
                gnt_a = ~pri;
                gnt_b = pri;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    assign any_gnt = gnt_a | gnt_b;

    // Steer the winning port's operands into the shared shifter
    always_comb begin
        sel_x  = gnt_b ? x_b  : x_a;
        sel_sc = gnt_b ? sc_b : sc_a;
    end

`ifdef SHIFT_ARB_ROTATE_EN
    assign sel_md  = gnt_b ? md_b : md_a;
    assign shift_y = sel_md ? ror32(sel_x, sel_sc) : asr32(sel_x, sel_sc);
`else
    assign shift_y = asr32(sel_x, sel_sc);
`endif

    // Round-robin pointer moves to the loser after every grant, holds otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pri <= 1'b0;
        end else if (any_gnt) begin
            pri <= gnt_a;
        end
    end

    // Response strobes follow the grant by one cycle; res_y only loads on a grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_a <= 1'b0;
            rsp_b <= 1'b0;
            res_y <= 32'd0;
        end else begin
            rsp_a <= gnt_a;
            rsp_b <= gnt_b;
            if (any_gnt) begin
                res_y <= shift_y;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        req_a = 1'b0;
    logic [31:0] x_a = 32'd0;
    logic [4:0]  sc_a = 5'd0;
    logic        md_a = 1'b0;
    logic        req_b = 1'b0;
    logic [31:0] x_b = 32'd0;
    logic [4:0]  sc_b = 5'd0;
    logic        md_b = 1'b0;
    logic        gnt_a, gnt_b, rsp_a, rsp_b;
    logic [31:0] res_y;

    int checks = 0;
    int fails  = 0;

`ifdef SHIFT_ARB_ROTATE_EN
    localparam logic [31:0] ROT_EXP = 32'hF000_0000;
`else
    localparam logic [31:0] ROT_EXP = 32'h0000_0000;
`endif

    shift_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .req_a (req_a),
        .x_a   (x_a),
        .sc_a  (sc_a),
        .md_a  (md_a),
        .req_b (req_b),
        .x_b   (x_b),
        .sc_b  (sc_b),
        .md_b  (md_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .rsp_a (rsp_a),
        .rsp_b (rsp_b),
        .res_y (res_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance through one rising edge and land on the following falling edge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state, with a request already pending
        #2;
        req_a = 1'b1; x_a = 32'h8000_0010; sc_a = 5'd4; md_a = 1'b0;
        #1;
        chk("rst_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
        chk("rst_rsp", {30'd0, rsp_a, rsp_b}, 32'd0);
        chk("rst_res", res_y, 32'd0);

        // Single arithmetic request on A
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t1_gnt", {30'd0, gnt_a, gnt_b}, 32'd2);
        chk("t1_rsp_pre", {30'd0, rsp_a, rsp_b}, 32'd0);
        chk("t1_res_pre", res_y, 32'd0);
        cyc();
        chk("t1_rsp", {30'd0, rsp_a, rsp_b}, 32'd2);
        chk("t1_res", res_y, 32'hF800_0001);
        req_a = 1'b0;
        #1;
        chk("t1_gnt_drop", {30'd0, gnt_a, gnt_b}, 32'd0);
        cyc();
        chk("t1_rsp_end", {30'd0, rsp_a, rsp_b}, 32'd0);
        chk("t1_res_hold", res_y, 32'hF800_0001);

        // Rotate request on B (zero when rotate is not built)
        req_b = 1'b1; x_b = 32'h0000_000F; sc_b = 5'd4; md_b = 1'b1;
        #1;
        chk("t2_gnt", {30'd0, gnt_a, gnt_b}, 32'd1);
        cyc();
        chk("t2_rsp", {30'd0, rsp_a, rsp_b}, 32'd1);
        chk("t2_res", res_y, ROT_EXP);
        req_b = 1'b0; md_b = 1'b0;

        // Contention: both held, grants alternate A, B, A, B
        req_a = 1'b1; x_a = 32'h1234_5678; sc_a = 5'd16; md_a = 1'b0;
        req_b = 1'b1; x_b = 32'hA5A5_0F0F; sc_b = 5'd0;  md_b = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_gnt", {30'd0, gnt_a, gnt_b}, (i % 2 == 0) ? 32'd2 : 32'd1);
            if (i > 0) begin
                chk("t3_rsp", {30'd0, rsp_a, rsp_b}, (i % 2 == 1) ? 32'd2 : 32'd1);
                chk("t3_res", res_y, (i % 2 == 1) ? 32'h0000_1234 : 32'hA5A5_0F0F);
            end
            cyc();
        end

        // Stall for three cycles with both requests pending
        stall = 1'b1;
        #1;
        chk("t4_rsp_inflight", {30'd0, rsp_a, rsp_b}, 32'd1);
        chk("t4_res_inflight", res_y, 32'hA5A5_0F0F);
        chk("t4_gnt_s0", {30'd0, gnt_a, gnt_b}, 32'd0);
        cyc();
        chk("t4_rsp_s1", {30'd0, rsp_a, rsp_b}, 32'd0);
        chk("t4_gnt_s1", {30'd0, gnt_a, gnt_b}, 32'd0);
        cyc();
        chk("t4_rsp_s2", {30'd0, rsp_a, rsp_b}, 32'd0);
        chk("t4_gnt_s2", {30'd0, gnt_a, gnt_b}, 32'd0);
        chk("t4_res_hold", res_y, 32'hA5A5_0F0F);
        cyc();
        chk("t4_rsp_s3", {30'd0, rsp_a, rsp_b}, 32'd0);
        stall = 1'b0;
        #1;
        chk("t4_gnt_release", {30'd0, gnt_a, gnt_b}, 32'd2);
        cyc();
        chk("t4_rsp_a", {30'd0, rsp_a, rsp_b}, 32'd2);
        chk("t4_res_a", res_y, 32'h0000_1234);
        req_a = 1'b0;
        #1;
        chk("t4_gnt_b", {30'd0, gnt_a, gnt_b}, 32'd1);
        cyc();
        chk("t4_rsp_b", {30'd0, rsp_a, rsp_b}, 32'd1);
        chk("t4_res_b", res_y, 32'hA5A5_0F0F);
        req_b = 1'b0;

        // Async reset with a response in flight; max shift count
        req_a = 1'b1; x_a = 32'h8000_0000; sc_a = 5'd31; md_a = 1'b0;
        #1;
        chk("t5_gnt", {30'd0, gnt_a, gnt_b}, 32'd2);
        @(posedge clk);
        #2;
        chk("t5_rsp_pre", {30'd0, rsp_a, rsp_b}, 32'd2);
        chk("t5_res_pre", res_y, 32'hFFFF_FFFF);
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_rsp_rst", {30'd0, rsp_a, rsp_b}, 32'd0);
        chk("t5_res_rst", res_y, 32'd0);
        chk("t5_gnt_rst", {30'd0, gnt_a, gnt_b}, 32'd0);
        cyc();
        rst = 1'b1;
        #1;
        chk("t5_rsp_rel", {30'd0, rsp_a, rsp_b}, 32'd0);
        cyc();
        chk("t5_rsp_idle", {30'd0, rsp_a, rsp_b}, 32'd0);
        chk("t5_res_idle", res_y, 32'd0);
        req_a = 1'b1; req_b = 1'b1;
        #1;
        chk("t5_gnt_pri", {30'd0, gnt_a, gnt_b}, 32'd2);
        cyc();
        chk("t5_rsp_new", {30'd0, rsp_a, rsp_b}, 32'd2);
        chk("t5_res_new", res_y, 32'hFFFF_FFFF);
        req_a = 1'b0; req_b = 1'b0;
        cyc();
        chk("t5_rsp_end", {30'd0, rsp_a, rsp_b}, 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
